trade_signal_gen: RTL and testbench

Consumes the raw 8-bit price sample and the 32-sample moving average produced by the moving-average filter stage, and decides when to enter and exit a long position. A crossover with hysteresis, a warm-up gate and a post-trade cooldown suppress noise-driven trades. It emits one-cycle buy/sell pulses toward the Raspberry Pi GPIO output stage and keeps a running realised profit/loss and trade count.

---
 rtl/trade_signal_gen_pkg.sv | 22 ++
 rtl/trade_signal_gen_if.sv | 24 ++
 rtl/trade_signal_gen_pnl_sat_acc.sv | 36 +++
 rtl/trade_signal_gen.sv | 121 ++++++++++++
 tb/tb_trade_signal_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/trade_signal_gen_pkg.sv
// Shared types and constants for the trade signal generator and its siblings.
// Default THRESH/WARMUP/HOLD track the moving-average filter window.
package trade_pkg;

    localparam int PRICE_W = 8;
    localparam int PNL_W   = 16;
    localparam int DIFF_W  = PRICE_W + 1;
    localparam int CNT_W   = 8;

    localparam int THRESH_DEF = 4;
    localparam int WARMUP_DEF = 32;
    localparam int HOLD_DEF   = 16;

    typedef enum logic [2:0] {
        ST_WARM,
        ST_FLAT,
        ST_LONG,
        ST_COOL_FLAT,
        ST_COOL_LONG
    } state_t;

endpackage

// File: rtl/trade_signal_gen_if.sv
// Sample/decision bundle between the filter stage, the signal generator and the GPIO stage.
interface trade_signal_gen_if;

    logic                                  sample_valid_i;
    logic        [trade_pkg::PRICE_W-1:0]  price_i;
    logic        [trade_pkg::PRICE_W-1:0]  avg_i;
    logic                                  flush_i;
    logic                                  buy_o;
    logic                                  sell_o;
    logic                                  long_o;
    logic signed [trade_pkg::PNL_W-1:0]    pnl_o;
    logic        [trade_pkg::CNT_W-1:0]    trade_cnt_o;

    modport master (
        output sample_valid_i, price_i, avg_i, flush_i,
        input  buy_o, sell_o, long_o, pnl_o, trade_cnt_o
    );

    modport slave (
        input  sample_valid_i, price_i, avg_i, flush_i,
        output buy_o, sell_o, long_o, pnl_o, trade_cnt_o
    );

endinterface

// File: rtl/trade_signal_gen_pnl_sat_acc.sv
// Signed saturating accumulate step: o_acc = clamp(i_acc + i_delta) when enabled.
// o_sat flags that the result was clipped to a rail.
module pnl_sat_acc
    import trade_pkg::*;
(
    input  logic                     i_en,
    input  logic signed [DIFF_W-1:0] i_delta,
    input  logic signed [PNL_W-1:0]  i_acc,
    output logic signed [PNL_W-1:0]  o_acc,
    output logic                     o_sat
);

    localparam logic signed [PNL_W:0] SUM_MAX = $signed({2'b00, {(PNL_W-1){1'b1}}});
    localparam logic signed [PNL_W:0] SUM_MIN = $signed({2'b11, {(PNL_W-1){1'b0}}});

    function automatic logic signed [PNL_W-1:0] sat_pnl(input logic signed [PNL_W:0] v);
        if (v > SUM_MAX) begin
            return SUM_MAX[PNL_W-1:0];
        end else if (v < SUM_MIN) begin
            return SUM_MIN[PNL_W-1:0];
        end
        return v[PNL_W-1:0];
    endfunction

    logic signed [PNL_W:0] w_acc_ext;
    logic signed [PNL_W:0] w_delta_ext;
    logic signed [PNL_W:0] w_sum;

    assign w_acc_ext   = {i_acc[PNL_W-1], i_acc};
    assign w_delta_ext = {{(PNL_W+1-DIFF_W){i_delta[DIFF_W-1]}}, i_delta};
    assign w_sum       = w_acc_ext + w_delta_ext;

    assign o_acc = i_en ? sat_pnl(w_sum) : i_acc;
    assign o_sat = i_en && ((w_sum > SUM_MAX) || (w_sum < SUM_MIN));

endmodule

// File: rtl/trade_signal_gen.sv
// Crossover-with-hysteresis long-only trade decision with warm-up and post-trade cooldown.
// Emits registered buy/sell pulses and keeps realised P&L and round-trip count.
module trade_signal_gen
    import trade_pkg::*;
#(
    parameter int THRESH = THRESH_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int HOLD   = HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    trade_signal_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [DIFF_W-1:0] THRESH_Z  = DIFF_W'(THRESH);

    state_t                    r_state;
    logic        [CNT_W-1:0]   r_warm_cnt;
    logic        [CNT_W-1:0]   r_cool_cnt;
    logic        [PRICE_W-1:0] r_entry;
    logic                      r_buy;
    logic                      r_sell;
    logic                      r_long;
    logic signed [PNL_W-1:0]   r_pnl;
    logic                      r_pnl_sat;
    logic        [CNT_W-1:0]   r_trade_cnt;

    logic        [DIFF_W-1:0]  w_price_z;
    logic        [DIFF_W-1:0]  w_avg_z;
    logic                      w_buy_cond;
    logic                      w_sell_cond;
    logic                      w_buy_evt;
    logic                      w_sell_evt;
    logic signed [DIFF_W-1:0]  w_delta;
    logic signed [PNL_W-1:0]   w_pnl_nxt;
    logic                      w_pnl_clip;

    // Zero-extended operands keep avg+THRESH and price+THRESH from wrapping.
    assign w_price_z   = {1'b0, bus.price_i};
    assign w_avg_z     = {1'b0, bus.avg_i};
    assign w_buy_cond  = w_price_z > (w_avg_z + THRESH_Z);
    assign w_sell_cond = (w_price_z + THRESH_Z) < w_avg_z;

    assign w_buy_evt  = bus.sample_valid_i && (r_state == ST_FLAT) && w_buy_cond;
    assign w_sell_evt = bus.sample_valid_i &&
                        (((r_state == ST_LONG) && (w_sell_cond || bus.flush_i)) ||
                         ((r_state == ST_COOL_LONG) && bus.flush_i));

    assign w_delta = $signed(w_price_z - {1'b0, r_entry});

    // Once clipped, P&L is frozen at the rail until reset.
    pnl_sat_acc u_pnl_acc (
        .i_en    (w_sell_evt && !r_pnl_sat),
        .i_delta (w_delta),
        .i_acc   (r_pnl),
        .o_acc   (w_pnl_nxt),
        .o_sat   (w_pnl_clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WARM;
            r_warm_cnt  <= '0;
            r_cool_cnt  <= '0;
            r_entry     <= '0;
            r_buy       <= 1'b0;
            r_sell      <= 1'b0;
            r_long      <= 1'b0;
            r_pnl       <= '0;
            r_pnl_sat   <= 1'b0;
            r_trade_cnt <= '0;
        end else begin
            r_buy  <= w_buy_evt;
            r_sell <= w_sell_evt;
            if (w_sell_evt) begin
                r_pnl      <= w_pnl_nxt;
                r_pnl_sat  <= r_pnl_sat | w_pnl_clip;
                if (r_trade_cnt != '1) begin
                    r_trade_cnt <= r_trade_cnt + 1'b1;
                end
                r_state    <= ST_COOL_FLAT;
                r_cool_cnt <= '0;
                r_long     <= 1'b0;
            end else if (w_buy_evt) begin
                r_entry    <= bus.price_i;
                r_state    <= ST_COOL_LONG;
                r_cool_cnt <= '0;
                r_long     <= 1'b1;
            end else if (bus.sample_valid_i) begin
                case (r_state)
                    ST_WARM: begin
                        if (r_warm_cnt == WARM_LAST) begin
                            r_state <= ST_FLAT;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + 1'b1;
                        end
                    end
                    ST_COOL_FLAT, ST_COOL_LONG: begin
                        if (r_cool_cnt == HOLD_LAST) begin
                            r_cool_cnt <= '0;
                            r_state    <= (r_state == ST_COOL_LONG) ? ST_LONG : ST_FLAT;
                        end else begin
                            r_cool_cnt <= r_cool_cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.buy_o       = r_buy;
    assign bus.sell_o      = r_sell;
    assign bus.long_o      = r_long;
    assign bus.pnl_o       = r_pnl;
    assign bus.trade_cnt_o = r_trade_cnt;

endmodule

// File: tb/tb_trade_signal_gen.sv
// Directed and randomized stimulus for trade_signal_gen against a sample-level trading model.
module tb_trade_signal_gen;

    localparam int THRESH = 4;
    localparam int WARMUP = 32;
    localparam int HOLD   = 16;

    logic clk;
    logic rst_n;

    trade_signal_gen_if bus ();

    trade_signal_gen #(
        .THRESH (THRESH),
        .WARMUP (WARMUP),
        .HOLD   (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: samples remaining in warm-up / cooldown, position flag, realised P&L.
    int m_warm;
    int m_cool;
    bit m_hold;
    int m_entry;
    int m_pnl;
    bit m_stuck;
    int m_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_warm  = WARMUP;
        m_cool  = 0;
        m_hold  = 0;
        m_entry = 0;
        m_pnl   = 0;
        m_stuck = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input int p, input int a, input bit f, output bit eb, output bit es);
        bit buy_now;
        bit sell_now;
        buy_now  = 0;
        sell_now = 0;
        if (m_warm > 0) begin
            m_warm--;
        end else if (m_cool > 0) begin
            if (m_hold && f) sell_now = 1;
            else m_cool--;
        end else if (!m_hold) begin
            buy_now = (p > a + THRESH);
        end else begin
            sell_now = f || (p + THRESH < a);
        end
        if (buy_now) begin
            m_hold  = 1;
            m_entry = p;
            m_cool  = HOLD;
        end
        if (sell_now) begin
            m_hold = 0;
            if (!m_stuck) begin
                m_pnl = m_pnl + (p - m_entry);
                if (m_pnl > 32767) begin
                    m_pnl   = 32767;
                    m_stuck = 1;
                end else if (m_pnl < -32768) begin
                    m_pnl   = -32768;
                    m_stuck = 1;
                end
            end
            if (m_cnt < 255) m_cnt++;
            m_cool = HOLD;
        end
        eb = buy_now;
        es = sell_now;
    endtask

    task automatic drive(input bit v, input int p, input int a, input bit f);
        bit eb;
        bit es;
        bus.sample_valid_i = v;
        bus.price_i        = 8'(p);
        bus.avg_i          = 8'(a);
        bus.flush_i        = f;
        @(posedge clk);
        #1;
        eb = 0;
        es = 0;
        if (v) model_step(p, a, f, eb, es);
        chk("buy_o",       int'(bus.buy_o),         int'(eb));
        chk("sell_o",      int'(bus.sell_o),        int'(es));
        chk("long_o",      int'(bus.long_o),        int'(m_hold));
        chk("pnl_o",       int'($signed(bus.pnl_o)), m_pnl);
        chk("trade_cnt_o", int'(bus.trade_cnt_o),   m_cnt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_buy"},  int'(bus.buy_o),          0);
        chk({tag, "_sell"}, int'(bus.sell_o),         0);
        chk({tag, "_long"}, int'(bus.long_o),         0);
        chk({tag, "_pnl"},  int'($signed(bus.pnl_o)), 0);
        chk({tag, "_cnt"},  int'(bus.trade_cnt_o),    0);
    endtask

    task automatic drive_random(input int n);
        for (int i = 0; i < n; i++) begin
            int p;
            int a;
            p = int'($urandom_range(0, 255));
            a = p + int'($urandom_range(0, 40)) - 20;
            if (a < 0) a = 0;
            if (a > 255) a = 255;
            drive($urandom_range(0, 3) != 0, p, a, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.sample_valid_i = 1'b0;
        bus.price_i        = '0;
        bus.avg_i          = '0;
        bus.flush_i        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Warm-up: 32 samples consumed, 33rd buys.
        for (int i = 0; i < WARMUP + 1; i++) drive(1, 200, 10, 0);
        for (int i = 0; i < HOLD; i++) drive(1, 200, 10, 0);
        drive(1, 120, 200, 1);
        for (int i = 0; i < HOLD; i++) drive(1, 50, 50, 0);

        // Hysteresis edge: +4 holds off, +5 buys.
        drive(1, 54, 50, 0);
        drive(1, 55, 50, 0);

        // Cooldown counts valid samples only; sell conditions inside it are ignored.
        for (int i = 0; i < 2 * HOLD; i++) drive(i % 2 == 0, 10, 100, 0);
        drive(1, 10, 100, 0);

        // Flush in FLAT is ignored.
        for (int i = 0; i < HOLD; i++) drive(1, 50, 50, 0);
        drive(1, 50, 50, 1);

        // Buy at 100, flush inside COOL_LONG at 120.
        drive(1, 100, 90, 0);
        drive(1, 120, 200, 1);

        // Buy at 100, wait out cooldown, sell at 50.
        for (int i = 0; i < HOLD; i++) drive(1, 60, 60, 0);
        drive(1, 100, 90, 0);
        for (int i = 0; i < HOLD; i++) drive(1, 60, 60, 0);
        drive(1, 50, 60, 0);

        drive_random(3000);

        // Repeated large gains until P&L clamps.
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 20000 && extra < 40; i++) begin
                if (m_hold) drive(1, 255, 0, 1);
                else drive(1, 5, 0, 0);
                if (m_stuck) extra++;
            end
        end
        chk("pnl_clamp", int'($signed(bus.pnl_o)), 32767);
        drive(1, 5, 0, 1);

        // Reach LONG, then assert reset asynchronously.
        for (int i = 0; i < 40 && (m_hold || m_cool > 0 || m_warm > 0); i++) drive(1, 100, 100, 1);
        drive(1, 150, 100, 0);
        for (int i = 0; i < HOLD; i++) drive(1, 100, 100, 0);
        chk("long_before_rst", int'(bus.long_o), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.sample_valid_i = 1'b1;
        bus.price_i        = 8'd10;
        bus.avg_i          = 8'd200;
        bus.flush_i        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("held_rst");
        model_reset();
        rst_n = 1'b1;
        drive_random(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
